// File: rtl/stream_xor_if.sv
// stream_xor_if -- bundle of the three byte-stream channels used by stream_xor.
//   ks_*  : keystream bits from the cipher core (ks_bit/ks_valid in, ks_ready out)
//   pt_*  : plaintext bytes (pt_data/pt_valid in, pt_ready out)
//   ct_*  : ciphertext bytes (ct_data/ct_valid out, ct_ready in)
// The slave modport is the stream_xor view; master is the environment view.
interface stream_xor_if;
  logic       ks_bit;
  logic       ks_valid;
  logic       ks_ready;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_ready;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_ready;

  modport master (
    output ks_bit, ks_valid,
    input  ks_ready,
    output pt_data, pt_valid,
    input  pt_ready,
    input  ct_data, ct_valid,
    output ct_ready
  );

  modport slave (
    input  ks_bit, ks_valid,
    output ks_ready,
    input  pt_data, pt_valid,
    output pt_ready,
    output ct_data, ct_valid,
    input  ct_ready
  );
endinterface

// File: rtl/stream_xor.sv
// stream_xor -- assembles 8 keystream bits (LSB first) into a byte, XORs it
// with one plaintext byte and presents the ciphertext byte downstream,
// repeating for msg_len bytes per message.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   start    : one-cycle message request (honoured only in IDLE)
//   msg_len  : message length in bytes, sampled on an accepted start
//   bus      : ks/pt/ct stream channels (slave side)
//   busy     : high whenever the FSM is not IDLE
//   done     : one-cycle pulse at message end (also for a zero-length start)
//   byte_cnt : ciphertext bytes delivered in the current or last message
//
// state   | meaning
// IDLE    | waiting for start
// FILL    | collecting 8 keystream bits
// WAIT_PT | keystream byte ready, waiting for a plaintext byte
// OUT     | ciphertext byte held until the downstream takes it
module stream_xor #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  stream_xor_if.slave      bus,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    WAIT_PT = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [LEN_W-1:0] len_q;
  logic [2:0]       bit_idx;
  logic [7:0]       ks_byte;
  logic [7:0]       ct_data_q;
  logic             ct_valid_q;
  logic             ks_rdy;
  logic             pt_rdy;

  logic             ks_xfer;
  logic             pt_xfer;
  logic             ct_xfer;
  logic             start_go;
  logic             start_zero;
  logic             last_byte;
  logic [LEN_W-1:0] cnt_inc;

  assign bus.ks_ready = ks_rdy;
  assign bus.pt_ready = pt_rdy;
  assign bus.ct_data  = ct_data_q;
  assign bus.ct_valid = ct_valid_q;

  assign ks_xfer    = ks_rdy & bus.ks_valid;
  assign pt_xfer    = pt_rdy & bus.pt_valid;
  assign ct_xfer    = (state == OUT) & ct_valid_q & bus.ct_ready;
  assign start_go   = (state == IDLE) & start & (msg_len != '0);
  assign start_zero = (state == IDLE) & start & (msg_len == '0);
  assign cnt_inc    = byte_cnt + 1'b1;
  assign last_byte  = (cnt_inc == len_q);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = FILL;
      FILL:    if (ks_xfer && bit_idx == 3'd7) state_nxt = WAIT_PT;
      WAIT_PT: if (pt_xfer) state_nxt = OUT;
      OUT:     if (ct_xfer) state_nxt = last_byte ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    ks_rdy = 1'b0;
    pt_rdy = 1'b0;
    busy   = 1'b1;
    case (state)
      IDLE:    busy   = 1'b0;
      FILL:    ks_rdy = 1'b1;
      WAIT_PT: pt_rdy = 1'b1;
      default: ;
    endcase
  end

  // datapath: length latch, keystream assembly, ciphertext register, counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      bit_idx    <= '0;
      ks_byte    <= '0;
      ct_data_q  <= '0;
      ct_valid_q <= 1'b0;
      byte_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (start_go) begin
        len_q    <= msg_len;
        byte_cnt <= '0;
        bit_idx  <= '0;
        ks_byte  <= '0;
      end else if (start_zero) begin
        byte_cnt <= '0;
        done     <= 1'b1;
      end

      // 3-bit index wraps to 0 after the 8th bit on its own
      if (ks_xfer) begin
        ks_byte[bit_idx] <= bus.ks_bit;
        bit_idx          <= bit_idx + 3'd1;
      end

      if (pt_xfer) begin
        ct_data_q  <= bus.pt_data ^ ks_byte;
        ct_valid_q <= 1'b1;
      end

      if (ct_xfer) begin
        ct_valid_q <= 1'b0;
        byte_cnt   <= cnt_inc;
        if (last_byte) done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/stream_xor.md
STREAM_XOR -- requirements
Module: stream_xor

Interface
REQ-001 SHALL have parameter LEN_W, default 16, the width of the message-length and byte counters.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a message.
REQ-005 SHALL have port msg_len  input  LEN_W  message length in bytes, sampled on accepted start.
REQ-006 SHALL have port ks_bit  input  1  keystream bit from the cipher core.
REQ-007 SHALL have port ks_valid  input  1  ks_bit valid.
REQ-008 SHALL have port ks_ready  output  1  block accepts ks_bit this cycle.
REQ-009 SHALL have port pt_data  input  8  plaintext byte.
REQ-010 SHALL have port pt_valid  input  1  pt_data valid.
REQ-011 SHALL have port pt_ready  output  1  block accepts pt_data this cycle.
REQ-012 SHALL have port ct_data  output  8  ciphertext byte.
REQ-013 SHALL have port ct_valid  output  1  ct_data valid.
REQ-014 SHALL have port ct_ready  input  1  downstream accepts ct_data.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at message end.
REQ-017 SHALL have port byte_cnt  output  LEN_W  count of ciphertext bytes delivered in current or last message.

Function
REQ-018 SHALL implement states IDLE, FILL, WAIT_PT and OUT.
REQ-019 SHALL define a transfer on any channel as valid and ready both high on the same rising edge.
REQ-020 In IDLE, start with msg_len!=0 SHALL latch msg_len, clear byte_cnt, bit index and keystream byte, and enter FILL next cycle.
REQ-021 In IDLE, start with msg_len==0 SHALL pulse done for one cycle and remain in IDLE, byte_cnt=0.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 ks_ready SHALL be high only in FILL; each keystream transfer stores ks_bit at bit position bit_idx (first bit to bit 0) and increments bit_idx.
REQ-024 The 8th keystream transfer SHALL move the state to WAIT_PT on the next cycle; bit_idx wraps to 0.
REQ-025 pt_ready SHALL be high only in WAIT_PT; a plaintext transfer SHALL register ct_data = pt_data XOR keystream byte, assert ct_valid and enter OUT next cycle.
REQ-026 In OUT, ct_data and ct_valid SHALL hold stable until a ciphertext transfer.
REQ-027 On a ciphertext transfer, byte_cnt SHALL increment by 1 and ct_valid deassert next cycle.
REQ-028 If the incremented byte_cnt equals the latched length, done SHALL pulse one cycle and the state returns to IDLE; otherwise the state returns to FILL.
REQ-029 Latency: 8th keystream bit accepted -> pt_ready high next cycle; plaintext accepted -> ct_valid high next cycle; peak throughput one byte per 10 cycles.
REQ-030 ks_valid or pt_valid asserted in a state where its ready is low SHALL have no effect.
REQ-031 byte_cnt SHALL hold its final value after done until the next accepted start.

Reset
REQ-032 While reset is high: state=IDLE, ks_ready=0, pt_ready=0, ct_valid=0, ct_data=0, busy=0, done=0, byte_cnt=0, bit index and keystream byte=0, latched length=0.
REQ-033 Reset asserted mid-message SHALL abort it immediately with no done pulse; a partial keystream byte SHALL be discarded.

Verification
REQ-034 msg_len=1, ks bits 1,0,1,1,0,0,1,0, pt 0xA5, ct_ready=1 -> ct_data=0xE8, done pulse, byte_cnt=1.
REQ-035 msg_len=0 start -> done one cycle after start, busy never high, no ready asserted.
REQ-036 msg_len=2, ct_ready low 5 cycles on byte 1 -> ct_data stable, ks_ready low throughout, byte_cnt 1 then 2, one done.
REQ-037 ks_valid toggled 1,0 every cycle -> 8 bits in 16 cycles, keystream byte correct, no lost/duplicated bits.
REQ-038 reset pulsed after 4 keystream bits of msg_len=3 -> all outputs at reset values, no done; new start msg_len=1 works normally.
REQ-039 start pulsed during OUT -> ignored; latched length and byte_cnt unchanged.
